// File: rtl/connect4_turn_ctrl.sv
// connect4_turn_ctrl: turn arbiter for the two-board Connect Four game.
// Owns the turn, takes one column request per turn over a req/ack handshake,
// issues one commit strobe per accepted move, waits for the win/full checker,
// then hands the turn to the other player. A per-turn timer forces a forfeit.
module connect4_turn_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CHECK_LAT      = 2,
  parameter int MAX_MOVES      = 42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       first_local,
  input  logic       local_req,
  input  logic [2:0] local_col,
  input  logic       remote_req,
  input  logic [2:0] remote_col,
  input  logic [6:0] col_full,
  input  logic       game_over,
  output logic       local_ack,
  output logic       local_nack,
  output logic       remote_ack,
  output logic       remote_nack,
  output logic       local_turn,
  output logic       commit_valid,
  output logic       commit_player,
  output logic [2:0] commit_col,
  output logic [5:0] move_count,
  output logic       timeout,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCAL_T  = 3'd1,
    REMOTE_T = 3'd2,
    COMMIT   = 3'd3,
    CHECK    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (CHECK_LAT < 1) ? 1 : $clog2(CHECK_LAT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CHECK_LAST = CW'(CHECK_LAT);
  localparam logic [5:0]    MOVES_LAST = 6'(MAX_MOVES);

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic [CW-1:0]   check_cnt_r;
  logic            local_armed_r;
  logic            remote_armed_r;

  logic            local_take_s;
  logic            remote_take_s;
  logic            local_good_s;
  logic            remote_good_s;
  logic            timer_last_s;
  logic [TW-1:0]   timer_next_s;

  // A column is playable only if it exists (0..6) and is not already full.
  function automatic logic col_ok(input logic [2:0] col, input logic [6:0] full);
    case (col)
      3'd0:    col_ok = ~full[0];
      3'd1:    col_ok = ~full[1];
      3'd2:    col_ok = ~full[2];
      3'd3:    col_ok = ~full[3];
      3'd4:    col_ok = ~full[4];
      3'd5:    col_ok = ~full[5];
      3'd6:    col_ok = ~full[6];
      default: col_ok = 1'b0;
    endcase
  endfunction

  // Request qualification and saturating turn-timer arithmetic.
  always_comb begin
    local_take_s  = local_req & local_armed_r;
    remote_take_s = remote_req & remote_armed_r;
    local_good_s  = local_take_s & col_ok(local_col, col_full);
    remote_good_s = remote_take_s & col_ok(remote_col, col_full);
    timer_last_s  = (timer_r == TIMER_LAST);
    if (timer_r >= TIMER_LAST) begin
      timer_next_s = TIMER_LAST;
    end else begin
      timer_next_s = timer_r + TW'(1'b1);
    end
  end

  // Turn FSM with registered handshake, commit and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      timer_r        <= '0;
      check_cnt_r    <= '0;
      local_armed_r  <= 1'b0;
      remote_armed_r <= 1'b0;
      local_ack      <= 1'b0;
      local_nack     <= 1'b0;
      remote_ack     <= 1'b0;
      remote_nack    <= 1'b0;
      local_turn     <= 1'b0;
      commit_valid   <= 1'b0;
      commit_player  <= 1'b0;
      commit_col     <= 3'd0;
      move_count     <= 6'd0;
      timeout        <= 1'b0;
      done           <= 1'b0;
    end else begin
      local_ack    <= 1'b0;
      local_nack   <= 1'b0;
      remote_ack   <= 1'b0;
      remote_nack  <= 1'b0;
      commit_valid <= 1'b0;
      // A held request is re-armed only after it has been seen low.
      if (!local_req) local_armed_r <= 1'b1;
      if (!remote_req) remote_armed_r <= 1'b1;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            move_count <= 6'd0;
            timer_r    <= '0;
            timeout    <= 1'b0;
            done       <= 1'b0;
            if (first_local) begin
              state_r    <= LOCAL_T;
              local_turn <= 1'b1;
            end else begin
              state_r    <= REMOTE_T;
              local_turn <= 1'b0;
            end
          end
        end
        LOCAL_T: begin
          timer_r <= timer_next_s;
          // A valid move on the last timer cycle beats the forfeit.
          if (local_good_s) begin
            local_ack     <= 1'b1;
            local_armed_r <= 1'b0;
            commit_player <= 1'b0;
            commit_col    <= local_col;
            local_turn    <= 1'b0;
            state_r       <= COMMIT;
          end else begin
            if (local_take_s) begin
              local_nack    <= 1'b1;
              local_armed_r <= 1'b0;
            end
            if (timer_last_s) begin
              timeout    <= 1'b1;
              done       <= 1'b1;
              local_turn <= 1'b0;
              state_r    <= DONE;
            end
          end
        end
        REMOTE_T: begin
          timer_r <= timer_next_s;
          if (remote_good_s) begin
            remote_ack     <= 1'b1;
            remote_armed_r <= 1'b0;
            commit_player  <= 1'b1;
            commit_col     <= remote_col;
            state_r        <= COMMIT;
          end else begin
            if (remote_take_s) begin
              remote_nack    <= 1'b1;
              remote_armed_r <= 1'b0;
            end
            if (timer_last_s) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        COMMIT: begin
          commit_valid <= 1'b1;
          if (move_count < MOVES_LAST) begin
            move_count <= move_count + 6'd1;
          end
          check_cnt_r <= '0;
          state_r     <= CHECK;
        end
        CHECK: begin
          // Give the board checker CHECK_LAT cycles before trusting game_over.
          if (check_cnt_r == CHECK_LAST) begin
            if (game_over || (move_count >= MOVES_LAST)) begin
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              timer_r <= '0;
              if (commit_player) begin
                state_r    <= LOCAL_T;
                local_turn <= 1'b1;
              end else begin
                state_r    <= REMOTE_T;
                local_turn <= 1'b0;
              end
            end
          end else begin
            check_cnt_r <= check_cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r    <= IDLE;
          local_turn <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Directed bench for connect4_turn_ctrl with a short turn timeout (20 cycles).
module tb_connect4_turn_ctrl;

  localparam int TO_CYC = 20;
  localparam int CHK_LAT = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       first_local;
  logic       local_req;
  logic [2:0] local_col;
  logic       remote_req;
  logic [2:0] remote_col;
  logic [6:0] col_full;
  logic       game_over;
  logic       local_ack;
  logic       local_nack;
  logic       remote_ack;
  logic       remote_nack;
  logic       local_turn;
  logic       commit_valid;
  logic       commit_player;
  logic [2:0] commit_col;
  logic [5:0] move_count;
  logic       timeout;
  logic       done;
  logic [17:0] all_outs;

  int checks;
  int failures;
  int exp_moves;

  connect4_turn_ctrl #(
    .TIMEOUT_CYCLES(TO_CYC),
    .CHECK_LAT(CHK_LAT),
    .MAX_MOVES(42)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .first_local(first_local),
    .local_req(local_req),
    .local_col(local_col),
    .remote_req(remote_req),
    .remote_col(remote_col),
    .col_full(col_full),
    .game_over(game_over),
    .local_ack(local_ack),
    .local_nack(local_nack),
    .remote_ack(remote_ack),
    .remote_nack(remote_nack),
    .local_turn(local_turn),
    .commit_valid(commit_valid),
    .commit_player(commit_player),
    .commit_col(commit_col),
    .move_count(move_count),
    .timeout(timeout),
    .done(done)
  );

  assign all_outs = {local_ack, local_nack, remote_ack, remote_nack, local_turn,
                     commit_valid, commit_player, commit_col, move_count, timeout, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted move: ack next cycle, commit the cycle after, then the check wait.
  task automatic do_move(input logic remote, input logic [2:0] col);
    if (remote) begin
      remote_req = 1'b1;
      remote_col = col;
    end else begin
      local_req = 1'b1;
      local_col = col;
    end
    tick;
    if (remote) chk("remote_ack", remote_ack, 1);
    else chk("local_ack", local_ack, 1);
    chk("commit_early", commit_valid, 0);
    if (remote) remote_req = 1'b0;
    else local_req = 1'b0;
    tick;
    exp_moves++;
    chk("ack_pulse", {local_ack, remote_ack}, 0);
    chk("commit_valid", commit_valid, 1);
    chk("commit_player", commit_player, remote);
    chk("commit_col", commit_col, col);
    chk("move_count", move_count, exp_moves);
    repeat (CHK_LAT + 1) tick;
    chk("commit_once", commit_valid, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_moves = 0;
    rst = 1'b1;
    start = 1'b0;
    first_local = 1'b0;
    local_req = 1'b0;
    local_col = 3'd0;
    remote_req = 1'b0;
    remote_col = 3'd0;
    col_full = 7'd0;
    game_over = 1'b0;
    tick;
    tick;
    chk("reset_outs", all_outs, 0);
    rst = 1'b0;
    tick;
    chk("idle_outs", all_outs, 0);

    // 1: local first, col 3
    start = 1'b1;
    first_local = 1'b1;
    tick;
    start = 1'b0;
    chk("t1_local_turn", local_turn, 1);
    do_move(1'b0, 3'd3);
    chk("t1_turn_passed", local_turn, 0);
    do_move(1'b1, 3'd0);
    chk("t1_back_local", local_turn, 1);

    // start mid-game is ignored
    start = 1'b1;
    first_local = 1'b0;
    tick;
    start = 1'b0;
    chk("start_ignored_turn", local_turn, 1);
    chk("start_ignored_moves", move_count, 2);

    // 2: full column nack, held req, out-of-range column, then valid col 4
    col_full = 7'b0000100;
    local_req = 1'b1;
    local_col = 3'd2;
    tick;
    chk("t2_nack", local_nack, 1);
    chk("t2_no_ack", local_ack, 0);
    tick;
    chk("t2_nack_once", local_nack, 0);
    tick;
    chk("t2_held_no_nack", {local_nack, local_ack, commit_valid}, 0);
    local_req = 1'b0;
    tick;
    local_req = 1'b1;
    local_col = 3'd7;
    tick;
    chk("t2_col7_nack", {local_nack, local_ack}, 2'b10);
    local_req = 1'b0;
    tick;
    do_move(1'b0, 3'd4);
    col_full = 7'd0;
    do_move(1'b1, 3'd1);

    // 3: remote request during local turn is ignored, then honoured on its turn
    remote_req = 1'b1;
    remote_col = 3'd5;
    tick;
    chk("t3_remote_ignored", {remote_ack, remote_nack}, 0);
    tick;
    chk("t3_no_commit", {commit_valid, remote_ack, remote_nack}, 0);
    do_move(1'b0, 3'd6);
    do_move(1'b1, 3'd5);

    // 5b: game_over during CHECK after move 7
    game_over = 1'b1;
    do_move(1'b0, 3'd0);
    chk("t5b_done", done, 1);
    chk("t5b_moves", move_count, 7);
    chk("t5b_no_timeout", {timeout, local_turn}, 0);
    game_over = 1'b0;

    // 4: timeout after 20 idle cycles in the turn
    start = 1'b1;
    first_local = 1'b1;
    tick;
    start = 1'b0;
    exp_moves = 0;
    chk("t4_restart", {local_turn, move_count, timeout, done}, 9'b1_000000_0_0);
    repeat (TO_CYC - 1) tick;
    chk("t4_not_yet", {timeout, done, local_turn}, 3'b001);
    tick;
    chk("t4_timeout", {timeout, done, local_turn}, 3'b110);

    // 4b: request on the last timer cycle wins
    start = 1'b1;
    first_local = 1'b0;
    tick;
    start = 1'b0;
    chk("t4b_remote_turn", {local_turn, timeout, done}, 0);
    repeat (TO_CYC - 1) tick;
    do_move(1'b1, 3'd2);
    chk("t4b_no_timeout", {timeout, done}, 0);
    chk("t4b_local_turn", local_turn, 1);
    repeat (TO_CYC - 1) tick;
    chk("t4b_timer_cleared", timeout, 0);
    tick;
    chk("t4b_second_timeout", {timeout, done}, 2'b11);

    // 5: 42 alternating moves fill the panel
    start = 1'b1;
    first_local = 1'b1;
    tick;
    start = 1'b0;
    exp_moves = 0;
    for (int i = 0; i < 42; i++) begin
      do_move((i % 2) == 1, 3'(i % 7));
    end
    chk("t5_full_done", done, 1);
    chk("t5_full_moves", move_count, 42);
    chk("t5_full_no_timeout", {timeout, local_turn}, 0);

    // 6: reset while in COMMIT
    start = 1'b1;
    first_local = 1'b1;
    tick;
    start = 1'b0;
    local_req = 1'b1;
    local_col = 3'd1;
    tick;
    chk("t6_ack", local_ack, 1);
    local_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_async_reset", all_outs, 0);
    tick;
    chk("t6_reset_commit_dropped", all_outs, 0);
    rst = 1'b0;
    tick;
    chk("t6_idle", all_outs, 0);
    start = 1'b1;
    first_local = 1'b0;
    tick;
    start = 1'b0;
    chk("t6_remote_first", {local_turn, done}, 0);
    local_req = 1'b1;
    local_col = 3'd0;
    tick;
    chk("t6_local_ignored", {local_ack, local_nack}, 0);
    local_req = 1'b0;
    exp_moves = 0;
    do_move(1'b1, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
